// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the 8-bit datapath: sequences fetch/decode/execute,
// drives every datapath control input, and owns the NZCV flag register.
module mc_control_unit #(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [2:0] sh,
    input  logic [3:0] alu_flags,
    output logic       adr_source,
    output logic       mem_Write,
    output logic       ir_Write,
    output logic       reg_Write,
    output logic       alu_srcA,
    output logic       pc_Write,
    output logic [2:0] alu_control,
    output logic [1:0] alu_srcB,
    output logic [1:0] imm_src,
    output logic [3:0] RegSrc,
    output logic [1:0] result_src,
    output logic [2:0] shft_op,
    output logic [3:0] state_out,
    output logic [3:0] flags_q
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_ORR  = 3'b011;
    localparam logic [2:0] ALU_PASS = 3'b100;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    state_t     state, state_next;
    logic [3:0] cmd;
    logic       is_cmp;
    logic       cond_ok;
    logic       flag_n, flag_z, flag_c, flag_v;

    assign cmd    = funct[4:1];
    assign is_cmp = (cmd == CMD_CMP);
    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    function automatic logic [2:0] alu_decode(input logic [3:0] c);
        case (c)
            CMD_ADD: alu_decode = ALU_ADD;
            CMD_SUB: alu_decode = ALU_SUB;
            CMD_AND: alu_decode = ALU_AND;
            CMD_ORR: alu_decode = ALU_ORR;
            CMD_MOV: alu_decode = ALU_PASS;
            CMD_CMP: alu_decode = ALU_SUB;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

    // Condition codes are evaluated against the architectural flags, not the live ALU flags.
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = flag_z;
            4'b0001: cond_ok = !flag_z;
            4'b0010: cond_ok = flag_c;
            4'b0011: cond_ok = !flag_c;
            4'b0100: cond_ok = flag_n;
            4'b0101: cond_ok = !flag_n;
            4'b1010: cond_ok = (flag_n == flag_v);
            4'b1011: cond_ok = (flag_n != flag_v);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= FLAGS_RST;
        end else if ((state == EXECR || state == EXECI) && (funct[0] || is_cmp)) begin
            flags_q <= alu_flags;
        end
    end

    always_comb begin
        state_next  = FETCH;
        adr_source  = 1'b0;
        mem_Write   = 1'b0;
        ir_Write    = 1'b0;
        reg_Write   = 1'b0;
        alu_srcA    = 1'b0;
        pc_Write    = 1'b0;
        alu_control = ALU_ADD;
        alu_srcB    = 2'b00;
        imm_src     = 2'b00;
        RegSrc      = 4'b0000;
        result_src  = 2'b00;
        shft_op     = 3'b000;

        case (state)
            FETCH: begin
                ir_Write   = 1'b1;
                pc_Write   = 1'b1;
                alu_srcA   = 1'b1;
                alu_srcB   = 2'b10;
                result_src = 2'b10;
                state_next = DECODE;
            end
            DECODE: begin
                RegSrc[1] = (op == 2'b01);
                RegSrc[0] = (op == 2'b10);
                if (!cond_ok || op == 2'b11) begin
                    state_next = FETCH;
                end else begin
                    case (op)
                        2'b00:   state_next = funct[5] ? EXECI : EXECR;
                        2'b01:   state_next = MEMADR;
                        default: state_next = BRANCH;
                    endcase
                end
            end
            EXECR, EXECI: begin
                alu_control = alu_decode(cmd);
                if (state == EXECI) begin
                    alu_srcB = 2'b01;
                end else begin
                    shft_op = sh;
                end
                state_next = is_cmp ? FETCH : ALUWB;
            end
            ALUWB: begin
                reg_Write  = 1'b1;
                state_next = FETCH;
            end
            MEMADR: begin
                alu_srcB   = 2'b01;
                imm_src    = 2'b01;
                RegSrc[1]  = 1'b1;
                state_next = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr_source = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                reg_Write  = 1'b1;
                result_src = 2'b01;
                state_next = FETCH;
            end
            MEMWR: begin
                adr_source = 1'b1;
                mem_Write  = 1'b1;
                RegSrc[1]  = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                pc_Write   = 1'b1;
                alu_srcA   = 1'b1;
                alu_srcB   = 2'b01;
                imm_src    = 2'b10;
                result_src = 2'b10;
                RegSrc[0]  = 1'b1;
                // BL links the already-incremented PC into R14 alongside the PC update.
                if (funct[4]) begin
                    reg_Write   = 1'b1;
                    RegSrc[3:2] = 2'b11;
                end
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase

        // Reset suppresses every write-enable, even though the state decodes as FETCH.
        if (reset) begin
            mem_Write = 1'b0;
            ir_Write  = 1'b0;
            reg_Write = 1'b0;
            pc_Write  = 1'b0;
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: walks instruction classes through the FSM
// and compares state and control outputs against hand-computed values.
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [2:0] sh;
    logic [3:0] alu_flags;
    logic       adr_source, mem_Write, ir_Write, reg_Write, alu_srcA, pc_Write;
    logic [2:0] alu_control;
    logic [1:0] alu_srcB, imm_src, result_src;
    logic [3:0] RegSrc;
    logic [2:0] shft_op;
    logic [3:0] state_out, flags_q;

    int checks = 0;
    int errors = 0;

    mc_control_unit #(.FLAGS_RST(4'b0000)) dut (
        .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .sh(sh),
        .alu_flags(alu_flags), .adr_source(adr_source), .mem_Write(mem_Write),
        .ir_Write(ir_Write), .reg_Write(reg_Write), .alu_srcA(alu_srcA),
        .pc_Write(pc_Write), .alu_control(alu_control), .alu_srcB(alu_srcB),
        .imm_src(imm_src), .RegSrc(RegSrc), .result_src(result_src),
        .shft_op(shft_op), .state_out(state_out), .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [3:0] c, input logic [1:0] o,
                          input logic [5:0] f, input logic [2:0] s);
        cond  = c;
        op    = o;
        funct = f;
        sh    = s;
    endtask

    initial begin
        reset = 1'b1;
        alu_flags = 4'b0000;
        set_ir(4'b1110, 2'b00, 6'b101001, 3'b000);

        // Reset held
        #28;
        check("rst_state", state_out, 0);
        check("rst_pcw", pc_Write, 0);
        check("rst_irw", ir_Write, 0);
        check("rst_flags", flags_q, 4'b0000);
        #2 reset = 1'b0;
        #1;
        check("fetch_pcw", pc_Write, 1);
        check("fetch_irw", ir_Write, 1);
        check("fetch_srcB", alu_srcB, 2'b10);
        check("fetch_rsrc", result_src, 2'b10);
        check("fetch_srcA", alu_srcA, 1);

        // ADD immediate with S, flags 0100
        alu_flags = 4'b0100;
        tick(); check("add_s1", state_out, 1); check("add_dec_rw", reg_Write, 0);
        tick(); check("add_s7", state_out, 7); check("add_srcB", alu_srcB, 2'b01);
        check("add_imm", imm_src, 2'b00); check("add_aluc", alu_control, 3'b000);
        check("add_srcA", alu_srcA, 0); check("add_rw7", reg_Write, 0);
        check("add_flg_pre", flags_q, 4'b0000);
        tick(); check("add_s8", state_out, 8); check("add_rw8", reg_Write, 1);
        check("add_rs8", result_src, 2'b00); check("add_flags", flags_q, 4'b0100);
        tick(); check("add_s0", state_out, 0); check("add_rw0", reg_Write, 0);

        // ORR register with S and shift, flags 1000
        set_ir(4'b1110, 2'b00, 6'b011001, 3'b011); alu_flags = 4'b1000;
        tick(); check("orr_s1", state_out, 1);
        tick(); check("orr_s6", state_out, 6); check("orr_shft", shft_op, 3'b011);
        check("orr_aluc", alu_control, 3'b011); check("orr_srcB", alu_srcB, 2'b00);
        tick(); check("orr_s8", state_out, 8); check("orr_flags", flags_q, 4'b1000);
        tick();

        // AND register without S: flags must not move
        set_ir(4'b1110, 2'b00, 6'b000000, 3'b000); alu_flags = 4'b0011;
        tick(); tick(); check("and_aluc", alu_control, 3'b010);
        tick(); check("and_s8", state_out, 8); check("and_flags", flags_q, 4'b1000);
        tick();

        // MOV immediate (pass-B)
        set_ir(4'b1110, 2'b00, 6'b111010, 3'b101);
        tick(); tick(); check("mov_s7", state_out, 7); check("mov_aluc", alu_control, 3'b100);
        check("mov_shft", shft_op, 3'b000);
        tick(); tick();

        // CMP with S=0 still updates flags, no writeback
        set_ir(4'b1110, 2'b00, 6'b010100, 3'b000); alu_flags = 4'b0100;
        tick(); check("cmp_s1", state_out, 1);
        tick(); check("cmp_s6", state_out, 6); check("cmp_aluc", alu_control, 3'b001);
        check("cmp_rw", reg_Write, 0);
        tick(); check("cmp_s0", state_out, 0); check("cmp_flags", flags_q, 4'b0100);

        // BEQ taken (Z=1)
        set_ir(4'b0000, 2'b10, 6'b000000, 3'b000); alu_flags = 4'b0000;
        tick(); check("beq_s1", state_out, 1); check("beq_regsrc1", RegSrc, 4'b0001);
        tick(); check("beq_s9", state_out, 9); check("beq_pcw", pc_Write, 1);
        check("beq_imm", imm_src, 2'b10); check("beq_rw", reg_Write, 0);
        check("beq_regsrc", RegSrc, 4'b0001); check("beq_srcA", alu_srcA, 1);
        tick(); check("beq_s0", state_out, 0);

        // LDR
        set_ir(4'b1110, 2'b01, 6'b011001, 3'b000);
        tick(); check("ldr_s1", state_out, 1); check("ldr_regsrc1", RegSrc, 4'b0010);
        tick(); check("ldr_s2", state_out, 2); check("ldr_imm", imm_src, 2'b01);
        check("ldr_srcB", alu_srcB, 2'b01); check("ldr_regsrc2", RegSrc, 4'b0010);
        tick(); check("ldr_s3", state_out, 3); check("ldr_adr", adr_source, 1);
        check("ldr_rw3", reg_Write, 0);
        tick(); check("ldr_s4", state_out, 4); check("ldr_rw4", reg_Write, 1);
        check("ldr_rs4", result_src, 2'b01);
        tick(); check("ldr_s0", state_out, 0); check("ldr_flags", flags_q, 4'b0100);

        // STR
        set_ir(4'b1110, 2'b01, 6'b011000, 3'b000);
        tick(); tick(); check("str_s2", state_out, 2); check("str_mw2", mem_Write, 0);
        tick(); check("str_s5", state_out, 5); check("str_mw5", mem_Write, 1);
        check("str_adr", adr_source, 1); check("str_regsrc", RegSrc, 4'b0010);
        tick(); check("str_s0", state_out, 0); check("str_mw0", mem_Write, 0);

        // BNE not taken (Z=1)
        set_ir(4'b0001, 2'b10, 6'b000000, 3'b000);
        tick(); check("bne_s1", state_out, 1); check("bne_pcw", pc_Write, 0);
        check("bne_rw", reg_Write, 0); check("bne_mw", mem_Write, 0);
        tick(); check("bne_s0", state_out, 0);

        // BL always
        set_ir(4'b1110, 2'b10, 6'b010000, 3'b000);
        tick(); tick(); check("bl_s9", state_out, 9); check("bl_rw", reg_Write, 1);
        check("bl_regsrc", RegSrc, 4'b1101); check("bl_pcw", pc_Write, 1);
        tick(); check("bl_s0", state_out, 0);

        // Undefined op, then GE (N==V) and LT (N!=V) on flags 0100
        set_ir(4'b1110, 2'b11, 6'b000000, 3'b000);
        tick(); tick(); check("undef_s0", state_out, 0);
        set_ir(4'b1010, 2'b10, 6'b000000, 3'b000);
        tick(); tick(); check("ge_s9", state_out, 9);
        tick();
        set_ir(4'b1011, 2'b10, 6'b000000, 3'b000);
        tick(); tick(); check("lt_s0", state_out, 0);
        set_ir(4'b1111, 2'b00, 6'b001001, 3'b000);
        tick(); tick(); check("nv_s0", state_out, 0);

        // Reset asserted during MEMWR
        set_ir(4'b1110, 2'b01, 6'b000000, 3'b000);
        tick(); tick(); tick();
        check("abort_s5", state_out, 5); check("abort_mw_pre", mem_Write, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_mw", mem_Write, 0); check("abort_state", state_out, 0);
        check("abort_flags", flags_q, 4'b0000); check("abort_pcw", pc_Write, 0);
        #3 reset = 1'b0;
        #1 check("post_rst_irw", ir_Write, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
